ifu: RTL and testbench
======================

// Module: ifu
// PURPOSE
//  Instruction Fetch Unit: first stage of the RISC-V core front end. Holds the
//  program counter (PC), advances it by 4 bytes each clock, and drives the
//  32-bit instruction word read from an internal, preloaded instruction ROM.
//  No branch/jump redirect; strictly sequential fetch.
// PARAMETERS
//  PC_W       32  width of the PC register in bits
//  ROM_WORDS  32  instruction ROM depth in 32-bit words (byte span 4*ROM_WORDS)
//  RESET_PC   0   PC value loaded by reset
// PORTS
//  CLOCK             in   1   clock, all state changes on rising edge
//  RESET             in   1   reset, synchronous, active-low
//  INSTRUCTION_CODE  out  32  instruction word at current PC (combinational)
// BEHAVIOUR
//  - Internal register named PC (PC_W bits). It must stay at that hierarchical
//    name: benches probe it directly.
//  - Rising CLOCK with RESET==0: PC <= RESET_PC. With RESET==1: PC <= PC+4.
//  - RESET is sampled only on the clock edge. Asserting it mid-run takes effect
//    at the next rising edge. PC then holds RESET_PC for every edge where
//    RESET==0.
//  - Power-up: PC initialised to RESET_PC, so the output is defined before the
//    first reset edge.
//  - INSTRUCTION_CODE = ROM[PC[PC_W-1:2]]. It is an asynchronous read, so the new
//    word appears in the same cycle the PC updates (zero-cycle read latency).
//  - The output after reset is ROM[RESET_PC>>2]. Outputs carry no separate
//    reset value.
//  - PC[1:0] is always 00: the PC starts aligned and steps by 4. The low bits are
//    ignored for indexing.
//  - Out of range: PC >= 4*ROM_WORDS gives INSTRUCTION_CODE = 32'h00000000.
//  - Wrap: PC+4 wraps modulo 2^PC_W, with no saturation or flag.
//  - ROM contents are fixed at elaboration. Unlisted words are 0.
//    Operands for every entry: rs1=x1, rs2=x2.
//      0x00 ADD x3  32'h002081B3 (f7=0000000 f3=000)
//      0x04 HCF x4  32'h02208233 (f7=0000001 f3=000, halt-and-catch-fire)
//      0x08 OR  x5  32'h0020E2B3 (f3=110)
//      0x0C AND x6  32'h0020F333 (f3=111)
//      0x10 SLL x7  32'h002093B3 (f3=001)
//      0x14 SRL x8  32'h0020D433 (f3=101)
//      0x18 MUL x9  32'h0020A4B3 (f3=010, custom encoding)
//      0x1C XOR x10 32'h0020C533 (f3=100)
//  - All opcodes are 7'b0110011 (R-type).
//  - The IFU does not interpret instructions. An HCF fetch does not stop the PC.
// TESTING
//  1 Reset: RESET=0 over 2 edges -> PC==0, INSTRUCTION_CODE==32'h002081B3.
//  2 Increment: release RESET, 8 edges -> PC steps 4,8,..,32. The outputs follow
//    the ROM table; at PC=32 the output is 0.
//  3 HCF: reset, then 1 edge -> PC==4, output 32'h02208233, fields
//    f7=0000001 f3=000 op=0110011.
//  4 Mid-run reset: PC==20, drive RESET=0 between edges -> PC unchanged until the
//    edge, then 0. PC holds 0 while RESET stays low and restarts at 4 after release.
//  5 Out of range: run to PC=4*ROM_WORDS and beyond -> output 32'h00000000, and
//    PC keeps incrementing.
//  6 Wrap: force PC=2^PC_W-4, 1 edge -> PC==0, output 32'h002081B3.

Source files
------------

// File: rtl/ifu.sv
// Purpose : instruction fetch; sequential PC (+4 per clock) indexing a fixed instruction ROM.
// Latency : zero-cycle ROM read; INSTRUCTION_CODE follows PC combinationally within the cycle.
// Backpressure: none; fetch never stalls, and the PC advances on every clock outside reset.
//
// Ports:
//   CLOCK            - clock; all state changes on the rising edge
//   RESET            - synchronous, active-low; loads RESET_PC on every edge it is low
//   INSTRUCTION_CODE - 32-bit word at ROM[PC >> 2], or 0 when PC is past the ROM
//
// The PC register keeps the hierarchical name PC because benches probe it directly.

module ifu #(
  parameter int                PC_W      = 32,
  parameter int                ROM_WORDS = 32,
  parameter logic [PC_W-1:0]   RESET_PC  = '0
) (
  input  logic        CLOCK,
  input  logic        RESET,
  output logic [31:0] INSTRUCTION_CODE
);

  // Words that carry a real instruction; every other ROM word reads as 0.
  localparam int TABLE_WORDS = 8;

  // Program image. Every entry is R-type (opcode 0110011) with rs1=x1, rs2=x2.
  localparam logic [31:0] ROM_TABLE [TABLE_WORDS] = '{
    32'h002081B3,  // 0x00 ADD x3
    32'h02208233,  // 0x04 HCF x4 (halt-and-catch-fire; the IFU does not act on it)
    32'h0020E2B3,  // 0x08 OR  x5
    32'h0020F333,  // 0x0C AND x6
    32'h002093B3,  // 0x10 SLL x7
    32'h0020D433,  // 0x14 SRL x8
    32'h0020A4B3,  // 0x18 MUL x9 (custom encoding)
    32'h0020C533   // 0x1C XOR x10
  };

  // Byte address one past the last ROM word.
  localparam logic [PC_W-1:0] ROM_BYTES = PC_W'(4 * ROM_WORDS);

  // The declaration initialiser gives PC a defined value before the first
  // reset edge, so the fetched word is valid from time zero.
  logic [PC_W-1:0] PC = RESET_PC;

  logic [PC_W-3:0] word_idx;
  logic            in_rom;
  logic            in_table;

  // PC steps by 4 and wraps naturally modulo 2^PC_W.
  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      PC <= RESET_PC;
    end else begin
      PC <= PC + PC_W'(4);
    end
  end

  // PC[1:0] is always 00 in operation; only the word index selects the entry.
  // The range test uses the full PC so an out-of-range address never aliases
  // back into the table.
  assign word_idx = PC[PC_W-1:2];
  assign in_rom   = (PC < ROM_BYTES);
  assign in_table = (word_idx < (PC_W-2)'(TABLE_WORDS));

  always_comb begin
    INSTRUCTION_CODE = 32'h0000_0000;
    if (in_rom && in_table) begin
      INSTRUCTION_CODE = ROM_TABLE[word_idx[2:0]];
    end
  end

endmodule

// File: tb/tb_ifu.sv
// Purpose : directed self-checking bench for ifu (reset, stepping, HCF, mid-run reset, range, wrap).
// Latency : outputs sampled on the falling edge, half a cycle after the rising edge that updates PC.
// Backpressure: not applicable; the DUT fetches every cycle.

module tb_ifu;

  logic        clk;
  logic        rst;
  logic [31:0] instr;

  int n_total;
  int n_pass;

  // Expected ROM image, written out independently of the DUT.
  logic [31:0] exp_rom [8];

  ifu #(
    .PC_W      (32),
    .ROM_WORDS (32),
    .RESET_PC  (32'h0)
  ) dut (
    .CLOCK            (clk),
    .RESET            (rst),
    .INSTRUCTION_CODE (instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard bound on run time in case the sequence stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One rising edge, then back to the falling edge for sampling and driving.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] rom_word(input logic [31:0] pc);
    logic [31:0] w;
    w = 32'h0;
    if (pc < 32'd32) w = exp_rom[pc[4:2]];
    return w;
  endfunction

  initial begin
    logic [31:0] pc_exp;

    n_total = 0;
    n_pass  = 0;
    exp_rom[0] = 32'h002081B3;
    exp_rom[1] = 32'h02208233;
    exp_rom[2] = 32'h0020E2B3;
    exp_rom[3] = 32'h0020F333;
    exp_rom[4] = 32'h002093B3;
    exp_rom[5] = 32'h0020D433;
    exp_rom[6] = 32'h0020A4B3;
    exp_rom[7] = 32'h0020C533;

    // Power-up: PC defined before any edge.
    rst = 1'b0;
    #1;
    check("powerup_pc",    dut.PC, 32'h0);
    check("powerup_instr", instr,  32'h002081B3);

    // 1: reset held over two edges.
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("reset_pc",    dut.PC, 32'h0);
    check("reset_instr", instr,  32'h002081B3);

    // 2: release and step through the table and one word past it.
    rst = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      pc_exp = 32'(4 * i);
      check($sformatf("step_pc_%0d", i),    dut.PC, pc_exp);
      check($sformatf("step_instr_%0d", i), instr,  rom_word(pc_exp));
    end
    check("pc32_zero", instr, 32'h0);

    // 5: unlisted words inside the ROM, the ROM boundary, and beyond it.
    for (int i = 9; i <= 34; i++) begin
      tick();
      pc_exp = 32'(4 * i);
      check($sformatf("range_pc_%0d", i),    dut.PC, pc_exp);
      check($sformatf("range_instr_%0d", i), instr,  32'h0);
    end

    // 3: HCF fetch one edge after reset, with field decode.
    rst = 1'b0;
    tick();
    check("hcf_reset_pc", dut.PC, 32'h0);
    rst = 1'b1;
    tick();
    check("hcf_pc",    dut.PC, 32'h4);
    check("hcf_instr", instr,  32'h02208233);
    check("hcf_f7",    {25'h0, instr[31:25]}, {25'h0, 7'b0000001});
    check("hcf_f3",    {29'h0, instr[14:12]}, {29'h0, 3'b000});
    check("hcf_op",    {25'h0, instr[6:0]},   {25'h0, 7'b0110011});
    tick();
    check("hcf_no_stop_pc", dut.PC, 32'h8);

    // 4: mid-run reset at PC=20; takes effect only at the next edge.
    repeat (3) tick();
    check("mid_pc20",    dut.PC, 32'd20);
    check("mid_instr20", instr,  32'h0020D433);
    rst = 1'b0;
    #1;
    check("mid_pc_before_edge", dut.PC, 32'd20);
    @(negedge clk);
    check("mid_pc_after_edge", dut.PC, 32'h0);
    check("mid_instr_after",   instr,  32'h002081B3);
    tick();
    check("mid_pc_hold", dut.PC, 32'h0);
    rst = 1'b1;
    tick();
    check("mid_pc_restart", dut.PC, 32'h4);
    check("mid_instr_restart", instr, 32'h02208233);

    // 6: wrap from the top of the address space.
    force dut.PC = 32'hFFFF_FFFC;
    #1;
    release dut.PC;
    #1;
    check("wrap_top_pc",    dut.PC, 32'hFFFF_FFFC);
    check("wrap_top_instr", instr,  32'h0);
    tick();
    check("wrap_pc",    dut.PC, 32'h0);
    check("wrap_instr", instr,  32'h002081B3);
    tick();
    check("wrap_next_pc", dut.PC, 32'h4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
